// File: rtl/poly_solve_horner.sv
// Horner-rule polynomial evaluator: one multiply-accumulate per clock, enable/ready/valid handshake.
// Build option: define POLY_SOLVE_SAT_EN to saturate each Horner step instead of wrapping.
module poly_solve_horner #(
  parameter int XW     = 8,
  parameter int CW     = 16,
  parameter int RW     = 16,
  parameter int DEGREE = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [XW-1:0]            valor_x,
  input  logic [(DEGREE+1)*CW-1:0] coef,
  output logic [RW-1:0]            result,
  output logic                     ready,
  output logic                     valid,
  output logic                     overflow
);

  localparam int PW   = RW + XW;
  localparam int SW   = PW + 1;
  localparam int CNTW = $clog2(DEGREE + 1);

  localparam logic signed [RW-1:0] RMAX = {1'b0, {(RW-1){1'b1}}};
  localparam logic signed [RW-1:0] RMIN = {1'b1, {(RW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic signed [RW-1:0]   acc_reg, acc_next;
  logic [CNTW-1:0]        cnt_reg, cnt_next;
  logic                   sticky_reg, sticky_next;
  logic [RW-1:0]          result_reg, result_next;
  logic                   overflow_reg, overflow_next;
  logic signed [XW-1:0]   x_reg;

  logic signed [CW-1:0]   coef_in  [0:DEGREE];
  logic signed [CW-1:0]   coef_reg [0:DEGREE];

  logic                   accept;
  logic signed [PW-1:0]   prod;
  logic signed [SW-1:0]   sum;
  logic [SW-RW:0]         sum_top;
  logic                   step_ovf;
  logic signed [RW-1:0]   step_fit;

  assign accept = enable && (state_reg != RUN);

  // Operands are captured at accept so the caller may change them during RUN.
  genvar gi;
  generate
    for (gi = 0; gi <= DEGREE; gi++) begin : g_coef
      assign coef_in[gi] = coef[gi*CW +: CW];

      always_ff @(posedge clock) begin
        if (accept) begin
          coef_reg[gi] <= coef_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (accept) begin
      x_reg <= $signed(valor_x);
    end
  end

  // One Horner step computed at full precision, then fitted back to RW bits.
  always_comb begin
    prod     = PW'(acc_reg) * PW'(x_reg);
    sum      = SW'(prod) + SW'(coef_reg[cnt_reg]);
    sum_top  = sum[SW-1:RW-1];
    step_ovf = !((&sum_top) || !(|sum_top));
`ifdef POLY_SOLVE_SAT_EN
    if (step_ovf) begin
      step_fit = sum[SW-1] ? RMIN : RMAX;
    end else begin
      step_fit = sum[RW-1:0];
    end
`else
    step_fit = sum[RW-1:0];
`endif
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    sticky_next   = sticky_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (enable) begin
          acc_next    = RW'(coef_in[DEGREE]);
          cnt_next    = CNTW'(DEGREE - 1);
          sticky_next = 1'b0;
          state_next  = RUN;
        end else begin
          state_next  = IDLE;
        end
      end
      RUN: begin
        acc_next    = step_fit;
        sticky_next = sticky_reg | step_ovf;
        if (cnt_reg == '0) begin
          result_next   = step_fit;
          overflow_next = sticky_reg | step_ovf;
          state_next    = DONE;
        end else begin
          cnt_next = cnt_reg - CNTW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      sticky_reg   <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      sticky_reg   <= sticky_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
    end
  end

  assign result   = result_reg;
  assign overflow = overflow_reg;
  assign ready    = (state_reg != RUN);
  assign valid    = (state_reg == DONE);

endmodule

// File: tb/tb_poly_solve_horner.sv
// Self-checking bench for poly_solve_horner: DEGREE 2, 1 and 5 instances, vector table,
// directed handshake sequences and randomized checks against an integer Horner model.
module tb_poly_solve_horner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         en   [3];
  logic [7:0]   xin  [3];
  logic [255:0] cin  [3];
  logic [15:0]  res  [3];
  logic         rdy  [3];
  logic         val  [3];
  logic         ovf  [3];
  int           degs [3];

  int checks = 0;
  int errors = 0;

  poly_solve_horner #(.XW(8), .CW(16), .RW(16), .DEGREE(2)) u_d2 (
    .clock(clk), .reset(rst), .enable(en[0]), .valor_x(xin[0]), .coef(cin[0][47:0]),
    .result(res[0]), .ready(rdy[0]), .valid(val[0]), .overflow(ovf[0]));
  poly_solve_horner #(.XW(8), .CW(16), .RW(16), .DEGREE(1)) u_d1 (
    .clock(clk), .reset(rst), .enable(en[1]), .valor_x(xin[1]), .coef(cin[1][31:0]),
    .result(res[1]), .ready(rdy[1]), .valid(val[1]), .overflow(ovf[1]));
  poly_solve_horner #(.XW(8), .CW(16), .RW(16), .DEGREE(5)) u_d5 (
    .clock(clk), .reset(rst), .enable(en[2]), .valor_x(xin[2]), .coef(cin[2][95:0]),
    .result(res[2]), .ready(rdy[2]), .valid(val[2]), .overflow(ovf[2]));

  typedef struct {
    int           sel;
    logic [7:0]   x;
    logic [255:0] cv;
    longint       exp_r;
    bit           exp_o;
    int           exp_lat;
    string        name;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [255:0] cvec(input int c0, input int c1, input int c2,
                                        input int c3, input int c4, input int c5);
    logic [255:0] v;
    v = '0;
    v[15:0]  = 16'(c0);
    v[31:16] = 16'(c1);
    v[47:32] = 16'(c2);
    v[63:48] = 16'(c3);
    v[79:64] = 16'(c4);
    v[95:80] = 16'(c5);
    return v;
  endfunction

  // Reference: Horner steps in wide integer arithmetic, overflow if any step leaves 16-bit range.
  task automatic model(input int deg, input logic [7:0] x, input logic [255:0] cv,
                       output longint r, output bit o);
    longint xv, acc, s;
    xv  = longint'($signed(x));
    acc = longint'($signed(cv[deg*16 +: 16]));
    o   = 1'b0;
    for (int i = deg - 1; i >= 0; i--) begin
      s = acc * xv + longint'($signed(cv[i*16 +: 16]));
      if (s > 32767 || s < -32768) o = 1'b1;
`ifdef POLY_SOLVE_SAT_EN
      if (s > 32767) acc = 32767;
      else if (s < -32768) acc = -32768;
      else acc = s;
`else
      acc = longint'($signed(s[15:0]));
`endif
    end
    r = acc;
  endtask

  task automatic run_eval(input int s, input logic [7:0] x, input logic [255:0] cv,
                          output longint r, output bit o, output int lat);
    @(negedge clk);
    en[s] = 1'b1; xin[s] = x; cin[s] = cv;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    en[s] = 1'b0; xin[s] = 8'($urandom); cin[s] = {8{$urandom}};
    while (!val[s] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!val[s]) chk("valid_timeout", 0, 1);
    r = longint'($signed(res[s]));
    o = ovf[s];
  endtask

  vec_t   tbl [5];
  longint r, mr;
  bit     o, mo;
  int     lat, nv, t1, t2;
  longint r1, r2;

  initial begin
    degs = '{2, 1, 5};
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; xin[i] = '0; cin[i] = '0;
    end

    // Reset state
    #12;
    chk("rst_result", res[0], 0);
    chk("rst_valid", val[0], 0);
    chk("rst_ready", rdy[0], 1);
    chk("rst_overflow", ovf[0], 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef POLY_SOLVE_SAT_EN
    tbl[1] = '{0, 8'h80, cvec(0, 0, 2, 0, 0, 0), 32767, 1'b1, 3, "ovf"};
`else
    tbl[1] = '{0, 8'h80, cvec(0, 0, 2, 0, 0, 0), -32768, 1'b1, 3, "ovf"};
`endif
    tbl[0] = '{0, 8'd3,  cvec(7, -5, 2, 0, 0, 0), 10,    1'b0, 3, "basic"};
    tbl[2] = '{0, 8'h80, cvec(0, 0, 1, 0, 0, 0),  16384, 1'b0, 3, "ovf_followup"};
    tbl[3] = '{1, 8'hFC, cvec(5, 3, 0, 0, 0, 0),  -7,    1'b0, 2, "deg1"};
    tbl[4] = '{2, 8'd2,  cvec(1, 1, 1, 1, 1, 1),  63,    1'b0, 6, "deg5"};

    for (int i = 0; i < 5; i++) begin
      run_eval(tbl[i].sel, tbl[i].x, tbl[i].cv, r, o, lat);
      $display("vec %s: result %0d overflow %0d latency %0d", tbl[i].name, r, o, lat);
      chk({tbl[i].name, "_result"}, r, tbl[i].exp_r);
      chk({tbl[i].name, "_overflow"}, o, tbl[i].exp_o);
      chk({tbl[i].name, "_latency"}, lat, tbl[i].exp_lat);
    end

    // Basic again: ready low for the two RUN cycles, result held afterwards
    @(negedge clk);
    en[0] = 1'b1; xin[0] = 8'd3; cin[0] = cvec(7, -5, 2, 0, 0, 0);
    @(negedge clk);
    en[0] = 1'b0;
    chk("run1_ready", rdy[0], 0);
    @(negedge clk);
    chk("run2_ready", rdy[0], 0);
    @(negedge clk);
    chk("done_valid", val[0], 1);
    repeat (5) @(negedge clk);
    chk("hold_valid", val[0], 0);
    chk("hold_result", longint'($signed(res[0])), 10);
    $display("hold: result %0d after idle", $signed(res[0]));

    // Back-to-back with enable held high
    @(negedge clk);
    en[0] = 1'b1; xin[0] = 8'd1; cin[0] = cvec(1, 1, 1, 0, 0, 0);
    nv = 0; t1 = 0; t2 = 0; r1 = 0; r2 = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (val[0]) begin
        nv++;
        if (nv == 1) begin t1 = c; r1 = longint'($signed(res[0])); xin[0] = 8'd2; end
        else if (nv == 2) begin t2 = c; r2 = longint'($signed(res[0])); end
      end else if (nv >= 1) begin
        en[0] = 1'b0;
      end
    end
    $display("b2b: results %0d %0d at cycles %0d %0d", r1, r2, t1, t2);
    chk("b2b_first", r1, 3);
    chk("b2b_second", r2, 7);
    chk("b2b_spacing", t2 - t1, 3);
    chk("b2b_count", nv, 2);

    // Busy ignore: enable pulse during RUN must not start a second evaluation
    @(negedge clk);
    en[0] = 1'b1; xin[0] = 8'd3; cin[0] = cvec(7, -5, 2, 0, 0, 0);
    @(negedge clk);
    xin[0] = 8'd5;
    @(negedge clk);
    en[0] = 1'b0;
    nv = 0; r1 = 0;
    for (int c = 0; c < 10; c++) begin
      if (val[0]) begin nv++; r1 = longint'($signed(res[0])); end
      @(negedge clk);
    end
    $display("busy: valid count %0d result %0d", nv, r1);
    chk("busy_count", nv, 1);
    chk("busy_result", r1, 10);

    // Asynchronous reset in the second RUN cycle
    @(negedge clk);
    en[0] = 1'b1; xin[0] = 8'd3; cin[0] = cvec(7, -5, 2, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_result", res[0], 0);
    chk("midrst_valid", val[0], 0);
    chk("midrst_ready", rdy[0], 1);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (4) begin
      @(negedge clk);
      if (val[0]) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    run_eval(0, 8'hFE, cvec(4, 0, 3, 0, 0, 0), r, o, lat);
    $display("post-reset: result %0d latency %0d", r, lat);
    chk("postrst_result", r, 16);
    chk("postrst_latency", lat, 3);

    // Randomized against the model
    for (int k = 0; k < 40; k++) begin
      int s;
      logic [7:0] x;
      logic [255:0] cv;
      s  = int'($urandom_range(0, 2));
      x  = 8'($urandom);
      cv = {8{$urandom}};
      if (k % 2 == 0) begin
        for (int i = 0; i < 6; i++) cv[i*16 +: 16] = 16'(int'($urandom_range(0, 40)) - 20);
      end
      model(degs[s], x, cv, mr, mo);
      run_eval(s, x, cv, r, o, lat);
      $display("rand %0d deg %0d x %0d: result %0d/%0d overflow %0d/%0d lat %0d",
               k, degs[s], $signed(x), r, mr, o, mo, lat);
      chk("rand_result", r, mr);
      chk("rand_overflow", o, mo);
      chk("rand_latency", lat, degs[s] + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
